// File: rtl/usb4_lane_pkg.sv
// usb4_lane_pkg
//   Shared constants for the USB4 lane serializer/deserializer pair:
//   generation encodings, per-generation word lengths, the common bit-counter
//   width, and small decode helpers so both directions agree on them.
package usb4_lane_pkg;

    localparam logic [1:0] GEN4 = 2'b00;
    localparam logic [1:0] GEN3 = 2'b01;
    localparam logic [1:0] GEN2 = 2'b10;

    localparam int WORD_LEN_GEN4 = 8;
    localparam int WORD_LEN_GEN3 = 132;
    localparam int WORD_LEN_GEN2 = 66;

    // Counter must index every bit of the longest (Gen3) word.
    localparam int CNT_W = $clog2(132);

    localparam logic [CNT_W-1:0] LAST_GEN4 = CNT_W'(WORD_LEN_GEN4 - 1);
    localparam logic [CNT_W-1:0] LAST_GEN3 = CNT_W'(WORD_LEN_GEN3 - 1);
    localparam logic [CNT_W-1:0] LAST_GEN2 = CNT_W'(WORD_LEN_GEN2 - 1);

    // Index of the final bit of a word; 2'b11 decodes like Gen4.
    function automatic logic [CNT_W-1:0] word_last_f(input logic [1:0] gen);
        case (gen)
            GEN3:    return LAST_GEN3;
            GEN2:    return LAST_GEN2;
            default: return LAST_GEN4;
        endcase
    endfunction

    // Gen4 words travel MSB-first; Gen3/Gen2 words travel LSB-first.
    function automatic logic msb_first_f(input logic [1:0] gen);
        return !((gen == GEN3) || (gen == GEN2));
    endfunction

endpackage

// File: rtl/lane_deser_core.sv
// lane_deser_core
//   One lane's assembly shift register plus its output word register.
//   Ports:
//     clk, rst         clock; asynchronous active-low reset
//     sample           serial bit sampled on this edge
//     pos              word bit counter shared by both lanes
//     gen_speed        generation, selects the bit ordering
//     flush            clear the assembly register (idle, abort or word end)
//     load             copy the completed word to rx_parallel
//     rx_parallel      last completed word, unused upper bits zero
module lane_deser_core
    import usb4_lane_pkg::*;
#(
    parameter int WIDTH = 132
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic [CNT_W-1:0] pos,
    input  logic [1:0]       gen_speed,
    input  logic             flush,
    input  logic             load,
    output logic [WIDTH-1:0] rx_parallel
);

    logic [WIDTH-1:0] asm_q, asm_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] idx;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        idx  = msb_first_f(gen_speed) ? (LAST_GEN4 - pos) : pos;
        word = asm_q;
        word[idx] = sample;
        // The assembly register only ever holds bits below word_len, so the
        // loaded word naturally has zero upper bits.
        asm_d = flush ? '0 : word;
        par_d = load ? word : par_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q <= '0;
            par_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            asm_q <= asm_d;
            par_q <= par_d;
        end
    end

    assign rx_parallel = par_q;

endmodule

// File: rtl/lanes_deserializer.sv
// lanes_deserializer
//   Samples one bit per clock from each of two USB4 lanes and reassembles
//   8-bit (Gen4), 132-bit (Gen3) or 66-bit (Gen2) words.
//   Ports:
//     clk, rst                 clock; asynchronous active-low reset
//     enable_deser             sample enable; first high cycle carries bit 0
//     gen_speed                00 Gen4, 01 Gen3, 10 Gen2, 11 as Gen4
//     lane_x_rx_ser            serial inputs
//     lane_x_rx_parallel       last completed word per lane
//     rx_valid, descr_rst      one-cycle pulse per completed word
//     enable_descr             high while enabled (one cycle lag)
module lanes_deserializer
    import usb4_lane_pkg::*;
#(
    parameter int WIDTH = 132
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_deser,
    input  logic [1:0]       gen_speed,
    input  logic             lane_0_rx_ser,
    input  logic             lane_1_rx_ser,
    output logic [WIDTH-1:0] lane_0_rx_parallel,
    output logic [WIDTH-1:0] lane_1_rx_parallel,
    output logic             rx_valid,
    output logic             descr_rst,
    output logic             enable_descr
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] ASSEMBLE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gen_q, gen_d;
    logic             rx_valid_q, rx_valid_d;
    logic             descr_rst_q, descr_rst_d;

    logic             abort;
    logic             sample_en;
    logic             last;

    always_comb begin
        // A generation change only aborts a word in progress; while idle the
        // first enabled edge must still carry bit 0.
        abort     = (state_q == ASSEMBLE) && (gen_speed != gen_q);
        sample_en = enable_deser && !abort;
        last      = sample_en && (cnt_q == word_last_f(gen_speed));

        cnt_d       = (sample_en && !last) ? cnt_q + 1'b1 : '0;
        state_d     = enable_deser ? ASSEMBLE : IDLE;
        gen_d       = gen_speed;
        rx_valid_d  = last;
        descr_rst_d = last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gen_q       <= GEN4;
            rx_valid_q  <= 1'b0;
            descr_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gen_q       <= gen_d;
            rx_valid_q  <= rx_valid_d;
            descr_rst_q <= descr_rst_d;
        end
    end

    // Flush whenever this edge does not extend the word: idle, abort or wrap.
    lane_deser_core #(.WIDTH(WIDTH)) u_lane_0 (
        .clk         (clk),
        .rst         (rst),
        .sample      (lane_0_rx_ser),
        .pos         (cnt_q),
        .gen_speed   (gen_speed),
        .flush       (!sample_en || last),
        .load        (last),
        .rx_parallel (lane_0_rx_parallel)
    );

    lane_deser_core #(.WIDTH(WIDTH)) u_lane_1 (
        .clk         (clk),
        .rst         (rst),
        .sample      (lane_1_rx_ser),
        .pos         (cnt_q),
        .gen_speed   (gen_speed),
        .flush       (!sample_en || last),
        .load        (last),
        .rx_parallel (lane_1_rx_parallel)
    );

    assign rx_valid     = rx_valid_q;
    assign descr_rst    = descr_rst_q;
    assign enable_descr = (state_q == ASSEMBLE);

endmodule

// File: tb/tb_lanes_deserializer.sv
// tb_lanes_deserializer
//   Directed bench for lanes_deserializer: Gen4/Gen3/Gen2 words, disable
//   mid-word, generation abort and asynchronous reset mid-word.
module tb_lanes_deserializer;

    localparam int W = 132;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable_deser = 1'b0;
    logic [1:0]   gen_speed = 2'b00;
    logic         lane_0_rx_ser = 1'b0;
    logic         lane_1_rx_ser = 1'b0;
    logic [W-1:0] lane_0_rx_parallel;
    logic [W-1:0] lane_1_rx_parallel;
    logic         rx_valid;
    logic         descr_rst;
    logic         enable_descr;

    int checks = 0;
    int errors = 0;

    lanes_deserializer #(.WIDTH(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .enable_deser       (enable_deser),
        .gen_speed          (gen_speed),
        .lane_0_rx_ser      (lane_0_rx_ser),
        .lane_1_rx_ser      (lane_1_rx_ser),
        .lane_0_rx_parallel (lane_0_rx_parallel),
        .lane_1_rx_parallel (lane_1_rx_parallel),
        .rx_valid           (rx_valid),
        .descr_rst          (descr_rst),
        .enable_descr       (enable_descr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit per lane, let the rising edge sample it, settle 1 time unit.
    task automatic step(input logic b0, input logic b1);
        lane_0_rx_ser = b0;
        lane_1_rx_ser = b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]   a0, a1;
        logic [W-1:0] w0, w1, u0, u1;
        logic [65:0]  g0, g1, h0, h1, j0, j1;
        int           vbad;
        int           dbad;

        // ---------------- reset state ----------------
        repeat (2) step(1'b0, 1'b0);
        check("reset_par0", lane_0_rx_parallel, '0);
        check("reset_par1", lane_1_rx_parallel, '0);
        check("reset_valid", W'(rx_valid), '0);
        check("reset_descr_rst", W'(descr_rst), '0);
        check("reset_enable_descr", W'(enable_descr), '0);
        rst = 1'b1;
        step(1'b0, 1'b0);

        // ---------------- Gen4 word ----------------
        gen_speed = 2'b00;
        enable_deser = 1'b1;
        a0 = 8'hA5;
        a1 = 8'h0F;
        vbad = 0;
        for (int i = 0; i < 8; i++) begin
            step(a0[7-i], a1[7-i]);
            if (i == 0) check("gen4_enable_descr_rise", W'(enable_descr), W'(1));
            if (i < 7 && (rx_valid || descr_rst)) vbad++;
        end
        check("gen4_early_valid", W'(vbad), '0);
        check("gen4_valid", W'(rx_valid), W'(1));
        check("gen4_descr_rst", W'(descr_rst), W'(1));
        check("gen4_par0", lane_0_rx_parallel, W'(8'hA5));
        check("gen4_par1", lane_1_rx_parallel, W'(8'h0F));
        step(1'b0, 1'b0);
        check("gen4_valid_drop", W'(rx_valid), '0);
        check("gen4_descr_rst_drop", W'(descr_rst), '0);
        check("gen4_par0_hold", lane_0_rx_parallel, W'(8'hA5));
        enable_deser = 1'b0;
        step(1'b0, 1'b0);
        check("gen4_enable_descr_fall", W'(enable_descr), '0);

        // ---------------- Gen3 back-to-back words ----------------
        gen_speed = 2'b01;
        step(1'b0, 1'b0);
        w0 = '0;
        w0[0] = 1'b1;
        w0[131] = 1'b1;
        for (int k = 0; k < W; k++) w1[k] = ((k % 3) == 0);
        u0 = '0;
        u0[64] = 1'b1;
        u1 = ~w1;
        enable_deser = 1'b1;
        vbad = 0;
        dbad = 0;
        for (int c = 1; c <= 264; c++) begin
            if (c <= 132) step(w0[(c-1) % 132], w1[(c-1) % 132]);
            else          step(u0[(c-1) % 132], u1[(c-1) % 132]);
            if (rx_valid !== ((c == 132) || (c == 264))) vbad++;
            if (descr_rst !== rx_valid) dbad++;
            if (c == 132) begin
                check("gen3_word1_par0", lane_0_rx_parallel, w0);
                check("gen3_word1_par1", lane_1_rx_parallel, w1);
            end
            if (c == 264) begin
                check("gen3_word2_par0", lane_0_rx_parallel, u0);
                check("gen3_word2_par1", lane_1_rx_parallel, u1);
            end
        end
        check("gen3_valid_cadence", W'(vbad), '0);
        check("gen3_descr_rst_tracks", W'(dbad), '0);

        // ---------------- Gen2 back-to-back words ----------------
        enable_deser = 1'b0;
        step(1'b0, 1'b0);
        gen_speed = 2'b10;
        g0 = 66'h2_DEAD_BEEF_1234_5678;
        g1 = 66'h1_8000_0000_0000_0001;
        h0 = 66'h0_0123_4567_89AB_CDEF;
        h1 = 66'h3_FFFF_0000_FFFF_0000;
        enable_deser = 1'b1;
        vbad = 0;
        for (int c = 1; c <= 132; c++) begin
            if (c <= 66) step(g0[(c-1) % 66], g1[(c-1) % 66]);
            else         step(h0[(c-1) % 66], h1[(c-1) % 66]);
            if (rx_valid !== ((c == 66) || (c == 132))) vbad++;
            if (c == 66) begin
                check("gen2_word1_par0", lane_0_rx_parallel, {66'b0, g0});
                check("gen2_word1_par1", lane_1_rx_parallel, {66'b0, g1});
            end
        end
        check("gen2_word2_par0", lane_0_rx_parallel, {66'b0, h0});
        check("gen2_word2_par1", lane_1_rx_parallel, {66'b0, h1});
        check("gen2_valid_cadence", W'(vbad), '0);

        // ---------------- disable after 40 Gen2 bits ----------------
        vbad = 0;
        for (int c = 1; c <= 40; c++) begin
            step(1'b1, 1'b1);
            if (rx_valid !== 1'b0 || enable_descr !== 1'b1) vbad++;
        end
        enable_deser = 1'b0;
        step(1'b1, 1'b1);
        check("partial_no_valid", W'(vbad + int'(rx_valid)), '0);
        check("partial_enable_descr_fall", W'(enable_descr), '0);
        check("partial_par0_hold", lane_0_rx_parallel, {66'b0, h0});
        repeat (3) step(1'b1, 1'b1);
        check("partial_idle_enable_descr", W'(enable_descr), '0);
        j0 = 66'h1_5555_AAAA_0F0F_F0F0;
        j1 = 66'h2_0000_0000_0000_0003;
        enable_deser = 1'b1;
        vbad = 0;
        for (int c = 1; c <= 66; c++) begin
            step(j0[c-1], j1[c-1]);
            if (c == 1) check("reenable_enable_descr_rise", W'(enable_descr), W'(1));
            if (c == 65) check("reenable_par0_hold", lane_0_rx_parallel, {66'b0, h0});
            if (rx_valid !== (c == 66)) vbad++;
        end
        check("reenable_valid_align", W'(vbad), '0);
        check("reenable_par0", lane_0_rx_parallel, {66'b0, j0});
        check("reenable_par1", lane_1_rx_parallel, {66'b0, j1});

        // ---------------- Gen3 -> Gen4 switch at bit 50 ----------------
        enable_deser = 1'b0;
        step(1'b0, 1'b0);
        gen_speed = 2'b01;
        enable_deser = 1'b1;
        vbad = 0;
        for (int c = 1; c <= 50; c++) begin
            step(1'b1, 1'b0);
            if (rx_valid !== 1'b0) vbad++;
        end
        gen_speed = 2'b00;
        step(1'b1, 1'b1);
        if (rx_valid !== 1'b0) vbad++;
        check("abort_par0_hold", lane_0_rx_parallel, {66'b0, j0});
        a0 = 8'h3C;
        a1 = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            step(a0[7-i], a1[7-i]);
            if (rx_valid !== (i == 7)) vbad++;
        end
        check("abort_valid_pattern", W'(vbad), '0);
        check("abort_gen4_par0", lane_0_rx_parallel, W'(8'h3C));
        check("abort_gen4_par1", lane_1_rx_parallel, W'(8'hC3));

        // ---------------- async reset mid-word ----------------
        repeat (3) step(1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_par0", lane_0_rx_parallel, '0);
        check("rst_async_par1", lane_1_rx_parallel, '0);
        check("rst_async_valid", W'(rx_valid), '0);
        check("rst_async_descr_rst", W'(descr_rst), '0);
        check("rst_async_enable_descr", W'(enable_descr), '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        a0 = 8'hA5;
        a1 = 8'h0F;
        vbad = 0;
        for (int i = 0; i < 8; i++) begin
            step(a0[7-i], a1[7-i]);
            if (rx_valid !== (i == 7)) vbad++;
        end
        check("rst_full_word_valid", W'(vbad), '0);
        check("rst_word_par0", lane_0_rx_parallel, W'(8'hA5));
        check("rst_word_par1", lane_1_rx_parallel, W'(8'h0F));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
